// File: rtl/regfile_scoreboard.sv
// Two-write, two-read register file with per-register busy bits
// for operand readiness tracking and destination reservation.
module regfile_scoreboard #(
    parameter int REGFILE_WIDTH      = 32,
    parameter int REGFILE_ADDR_WIDTH = 5,
    parameter int ZERO_REG           = 1,
    parameter int BYPASS             = 1
) (
    input  logic                          Clock,
    input  logic                          Reset_n,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_1,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Read_Addr_2,
    output logic [REGFILE_WIDTH-1:0]      Data_Out_1,
    output logic [REGFILE_WIDTH-1:0]      Data_Out_2,
    output logic                          Ready_1,
    output logic                          Ready_2,
    input  logic                          Write_enable_A,
    input  logic                          Write_enable_B,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Write_Addr_A,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Write_Addr_B,
    input  logic [REGFILE_WIDTH-1:0]      Data_In_A,
    input  logic [REGFILE_WIDTH-1:0]      Data_In_B,
    input  logic                          Reserve_enable,
    input  logic [REGFILE_ADDR_WIDTH-1:0] Reserve_Addr,
    output logic                          Reserve_grant,
    output logic [REGFILE_ADDR_WIDTH:0]   Busy_count
);

    localparam int AW    = REGFILE_ADDR_WIDTH;
    localparam int DW    = REGFILE_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = AW + 1;

    logic [DW-1:0]    regs_q [DEPTH];
    logic [DW-1:0]    regs_d [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    logic wr_a;
    logic wr_b;
    logic res_set;
    logic dec_a;
    logic dec_b;

    logic [AW-1:0] rd_addr [2];
    logic [DW-1:0] rd_data [2];
    logic          rd_rdy  [2];

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // B is dropped when A hits the same address, so at most one write per register
    assign wr_a = Write_enable_A && !is_zero(Write_Addr_A);
    assign wr_b = Write_enable_B && !is_zero(Write_Addr_B)
                  && !(wr_a && (Write_Addr_B == Write_Addr_A));

    assign Reserve_grant = Reserve_enable && !busy_q[Reserve_Addr];
    assign res_set       = Reserve_grant && !is_zero(Reserve_Addr);

    assign dec_a = wr_a && busy_q[Write_Addr_A];
    assign dec_b = wr_b && busy_q[Write_Addr_B];

    assign rd_addr[0] = Read_Addr_1;
    assign rd_addr[1] = Read_Addr_2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic hit_a;
        logic hit_b;

        assign hit_a = (BYPASS != 0) && wr_a && (Write_Addr_A == rd_addr[p]);
        assign hit_b = (BYPASS != 0) && wr_b && (Write_Addr_B == rd_addr[p]);

        assign rd_data[p] = is_zero(rd_addr[p]) ? '0
                          : hit_a ? Data_In_A
                          : hit_b ? Data_In_B
                          : regs_q[rd_addr[p]];

        assign rd_rdy[p] = is_zero(rd_addr[p]) || !busy_q[rd_addr[p]]
                           || hit_a || hit_b;
    end

    assign Data_Out_1 = rd_data[0];
    assign Data_Out_2 = rd_data[1];
    assign Ready_1    = rd_rdy[0];
    assign Ready_2    = rd_rdy[1];
    assign Busy_count = cnt_q;

    // A granted reservation is applied last so it wins over a same-cycle write
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_b) begin
            regs_d[Write_Addr_B] = Data_In_B;
            busy_d[Write_Addr_B] = 1'b0;
        end
        if (wr_a) begin
            regs_d[Write_Addr_A] = Data_In_A;
            busy_d[Write_Addr_A] = 1'b0;
        end
        if (res_set) begin
            busy_d[Reserve_Addr] = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CW'(res_set) - CW'(dec_a) - CW'(dec_b);
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed vector table followed by
// randomized traffic checked against a behavioural register-file model.
module tb_regfile_scoreboard;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic [4:0]  Read_Addr_1, Read_Addr_2;
    logic [31:0] Data_Out_1, Data_Out_2;
    logic        Ready_1, Ready_2;
    logic        Write_enable_A, Write_enable_B;
    logic [4:0]  Write_Addr_A, Write_Addr_B;
    logic [31:0] Data_In_A, Data_In_B;
    logic        Reserve_enable;
    logic [4:0]  Reserve_Addr;
    logic        Reserve_grant;
    logic [5:0]  Busy_count;

    always #5 Clock = ~Clock;

    regfile_scoreboard dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .Read_Addr_1    (Read_Addr_1),
        .Read_Addr_2    (Read_Addr_2),
        .Data_Out_1     (Data_Out_1),
        .Data_Out_2     (Data_Out_2),
        .Ready_1        (Ready_1),
        .Ready_2        (Ready_2),
        .Write_enable_A (Write_enable_A),
        .Write_enable_B (Write_enable_B),
        .Write_Addr_A   (Write_Addr_A),
        .Write_Addr_B   (Write_Addr_B),
        .Data_In_A      (Data_In_A),
        .Data_In_B      (Data_In_B),
        .Reserve_enable (Reserve_enable),
        .Reserve_Addr   (Reserve_Addr),
        .Reserve_grant  (Reserve_grant),
        .Busy_count     (Busy_count)
    );

    typedef struct {
        string       nm;
        logic        rst;
        logic        we_a;
        logic [4:0]  a_a;
        logic [31:0] d_a;
        logic        we_b;
        logic [4:0]  a_b;
        logic [31:0] d_b;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        y1;
        logic        y2;
        logic        g;
        logic [5:0]  c;
    } vec_t;

    typedef struct {
        string       nm;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        y1;
        logic        y2;
        logic        g;
        logic [5:0]  c;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    logic [31:0] mregs [32];
    logic [31:0] mbusy;
    int          mcnt;

    function automatic vec_t mk(string nm, bit rst,
                                bit wea, int aa, logic [31:0] da,
                                bit web, int ab, logic [31:0] db,
                                bit re, int ra, int r1, int r2,
                                logic [31:0] e1, logic [31:0] e2,
                                bit y1, bit y2, bit g, int c);
        vec_t v;
        v.nm = nm;     v.rst = rst;
        v.we_a = wea;  v.a_a = 5'(aa); v.d_a = da;
        v.we_b = web;  v.a_b = 5'(ab); v.d_b = db;
        v.re = re;     v.ra = 5'(ra);
        v.r1 = 5'(r1); v.r2 = 5'(r2);
        v.e1 = e1;     v.e2 = e2;
        v.y1 = y1;     v.y2 = y2;
        v.g = g;       v.c = 6'(c);
        return v;
    endfunction

    function automatic exp_t tab_exp(vec_t v);
        exp_t e;
        e.nm = v.nm; e.e1 = v.e1; e.e2 = v.e2;
        e.y1 = v.y1; e.y2 = v.y2; e.g = v.g; e.c = v.c;
        return e;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, act, req);
    endtask

    task automatic apply(vec_t v);
        Reset_n        = v.rst;
        Write_enable_A = v.we_a; Write_Addr_A = v.a_a; Data_In_A = v.d_a;
        Write_enable_B = v.we_b; Write_Addr_B = v.a_b; Data_In_B = v.d_b;
        Reserve_enable = v.re;   Reserve_Addr = v.ra;
        Read_Addr_1    = v.r1;   Read_Addr_2  = v.r2;
    endtask

    function automatic logic [31:0] mread(vec_t v, logic [4:0] r);
        if (r == 0) return 32'h0;
        if (v.we_a && v.a_a == r) return v.d_a;
        if (v.we_b && v.a_b == r) return v.d_b;
        return mregs[r];
    endfunction

    function automatic logic mrdy(vec_t v, logic [4:0] r);
        if (r == 0) return 1'b1;
        return !mbusy[r] || (v.we_a && v.a_a == r) || (v.we_b && v.a_b == r);
    endfunction

    function automatic exp_t model_exp(vec_t v);
        exp_t e;
        e.nm = "rnd";
        e.e1 = mread(v, v.r1);
        e.e2 = mread(v, v.r2);
        e.y1 = mrdy(v, v.r1);
        e.y2 = mrdy(v, v.r2);
        e.g  = v.re && !mbusy[v.ra];
        e.c  = 6'(mcnt);
        return e;
    endfunction

    task automatic model_step(vec_t v);
        logic g;
        g = v.re && !mbusy[v.ra];
        if (!v.rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
            mbusy = 32'h0;
        end else begin
            if (v.we_b && v.a_b != 0) begin
                mregs[v.a_b] = v.d_b;
                mbusy[v.a_b] = 1'b0;
            end
            if (v.we_a && v.a_a != 0) begin
                mregs[v.a_a] = v.d_a;
                mbusy[v.a_a] = 1'b0;
            end
            if (g && v.ra != 0) mbusy[v.ra] = 1'b1;
        end
        mcnt = $countones(mbusy);
    endtask

    always @(negedge Clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.nm, ".d1"},  Data_Out_1,         e.e1);
            chk({e.nm, ".d2"},  Data_Out_2,         e.e2);
            chk({e.nm, ".rdy1"}, 32'(Ready_1),       32'(e.y1));
            chk({e.nm, ".rdy2"}, 32'(Ready_2),       32'(e.y2));
            chk({e.nm, ".gnt"}, 32'(Reserve_grant), 32'(e.g));
            chk({e.nm, ".cnt"}, 32'(Busy_count),    32'(e.c));
        end
    end

    initial begin
        vec_t v;
        vec_t idle;
        idle = mk("idle", 1, 0,0,0, 0,0,0, 0,0, 0,0, 0,0,1,1,0,0);

        //          name         rst A:we,adr,data     B:we,adr,data   res  rd1,rd2 d1,d2 rdy1,rdy2,gnt,cnt
        vecs.push_back(mk("rst_gnt",    0, 0,0,0,             0,0,0,        1,9,  0,0,   0,0,1,1,1,0));
        vecs.push_back(mk("wrA_r5",     1, 1,5,32'hDEADBEEF,  0,0,0,        0,0,  5,6,   32'hDEADBEEF,0,1,1,0,0));
        vecs.push_back(mk("rd_r5",      1, 0,0,0,             0,0,0,        0,0,  5,0,   32'hDEADBEEF,0,1,1,0,0));
        vecs.push_back(mk("ab_r7",      1, 1,7,1,             1,7,2,        0,0,  7,7,   1,1,1,1,0,0));
        vecs.push_back(mk("rd_r7",      1, 0,0,0,             0,0,0,        0,0,  7,5,   1,32'hDEADBEEF,1,1,0,0));
        vecs.push_back(mk("res_r3",     1, 0,0,0,             0,0,0,        1,3,  3,3,   0,0,1,1,1,0));
        vecs.push_back(mk("res_r3_waw", 1, 0,0,0,             0,0,0,        1,3,  3,4,   0,0,0,1,0,1));
        vecs.push_back(mk("wr_r3",      1, 1,3,32'h55,        0,0,0,        1,3,  3,3,   32'h55,32'h55,1,1,0,1));
        vecs.push_back(mk("rd_r3",      1, 0,0,0,             0,0,0,        0,0,  3,3,   32'h55,32'h55,1,1,0,0));
        vecs.push_back(mk("wr_r0",      1, 1,0,32'hFFFF,      0,0,0,        0,0,  0,0,   0,0,1,1,0,0));
        vecs.push_back(mk("res_r0",     1, 0,0,0,             0,0,0,        1,0,  0,0,   0,0,1,1,1,0));
        vecs.push_back(mk("res_r1",     1, 0,0,0,             0,0,0,        1,1,  0,1,   0,0,1,1,1,0));
        vecs.push_back(mk("res_r2",     1, 0,0,0,             0,0,0,        1,2,  1,2,   0,0,0,1,1,1));
        vecs.push_back(mk("ab_r1r2",    1, 1,1,32'h11,        1,2,32'h22,   0,0,  1,2,   32'h11,32'h22,1,1,0,2));
        vecs.push_back(mk("rd_r1r2",    1, 0,0,0,             0,0,0,        0,0,  1,2,   32'h11,32'h22,1,1,0,0));
        vecs.push_back(mk("res_r20",    1, 0,0,0,             0,0,0,        1,20, 20,0,  0,0,1,1,1,0));
        vecs.push_back(mk("ab_r20",     1, 1,20,32'hA,        1,20,32'hB,   0,0,  20,20, 32'hA,32'hA,1,1,0,1));
        vecs.push_back(mk("rd_r20",     1, 0,0,0,             0,0,0,        0,0,  20,0,  32'hA,0,1,1,0,0));
        vecs.push_back(mk("res_wr_r21", 1, 1,21,32'h77,       0,0,0,        1,21, 21,0,  32'h77,0,1,1,1,0));
        vecs.push_back(mk("rd_r21",     1, 0,0,0,             0,0,0,        0,0,  21,20, 32'h77,32'hA,0,1,0,1));
        vecs.push_back(mk("wrB_r21",    1, 0,0,0,             1,21,32'h78,  0,0,  21,0,  32'h78,0,1,1,0,1));
        vecs.push_back(mk("rd_r21b",    1, 0,0,0,             0,0,0,        0,0,  21,0,  32'h78,0,1,1,0,0));
        vecs.push_back(mk("res_r10",    1, 0,0,0,             0,0,0,        1,10, 0,0,   0,0,1,1,1,0));
        vecs.push_back(mk("res_r11",    1, 0,0,0,             0,0,0,        1,11, 0,0,   0,0,1,1,1,1));
        vecs.push_back(mk("res_r12",    1, 0,0,0,             0,0,0,        1,12, 10,11, 0,0,0,0,1,2));
        vecs.push_back(mk("rst_mid",    0, 1,10,32'hAA,       0,0,0,        1,13, 12,10, 0,32'hAA,0,1,1,3));
        vecs.push_back(mk("post_rst",   1, 0,0,0,             0,0,0,        0,0,  5,7,   0,0,1,1,0,0));
        vecs.push_back(mk("post_rst2",  1, 0,0,0,             0,0,0,        0,0,  13,10, 0,0,1,1,0,0));

        apply(idle);
        Reset_n = 1'b0;
        repeat (3) @(posedge Clock);

        foreach (vecs[i]) begin
            #1;
            apply(vecs[i]);
            sb.push_back(tab_exp(vecs[i]));
            @(posedge Clock);
        end

        // Reset into a known state before handing over to the model
        #1;
        v = idle;
        v.rst = 1'b0;
        apply(v);
        model_step(v);
        @(posedge Clock);

        for (int n = 0; n < 400; n++) begin
            #1;
            v.nm   = "rnd";
            v.rst  = ($urandom_range(0, 39) != 0);
            v.we_a = ($urandom_range(0, 2) == 0);
            v.a_a  = 5'($urandom_range(0, 7));
            v.d_a  = $urandom;
            v.we_b = ($urandom_range(0, 2) == 0);
            v.a_b  = 5'($urandom_range(0, 7));
            v.d_b  = $urandom;
            v.re   = ($urandom_range(0, 1) == 0);
            v.ra   = 5'($urandom_range(0, 7));
            v.r1   = 5'($urandom_range(0, 7));
            v.r2   = 5'($urandom_range(0, 7));
            apply(v);
            sb.push_back(model_exp(v));
            model_step(v);
            @(posedge Clock);
        end

        #1;
        apply(idle);
        repeat (3) @(posedge Clock);
        chk("sb_drain", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter REGFILE_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter REGFILE_ADDR_WIDTH, default 5, address width; depth = 2**REGFILE_ADDR_WIDTH.
REQ-003 SHALL have parameter ZERO_REG, default 1, where 1 hardwires register 0 to zero.
REQ-004 SHALL have parameter BYPASS, default 1, where 1 enables same-cycle write-to-read forwarding.
REQ-005 SHALL have port Clock  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port Reset_n  input  1  reset, synchronous and active-low.
REQ-007 SHALL have ports Read_Addr_1, Read_Addr_2  input  REGFILE_ADDR_WIDTH  read port addresses.
REQ-008 SHALL have ports Data_Out_1, Data_Out_2  output  REGFILE_WIDTH  read data.
REQ-009 SHALL have ports Ready_1, Ready_2  output  1  operand valid, i.e. the addressed register is not busy.
REQ-010 SHALL have ports Write_enable_A, Write_enable_B  input  1  write strobes.
REQ-011 SHALL have ports Write_Addr_A, Write_Addr_B  input  REGFILE_ADDR_WIDTH  write addresses.
REQ-012 SHALL have ports Data_In_A, Data_In_B  input  REGFILE_WIDTH  write data.
REQ-013 SHALL have port Reserve_enable  input  1  request to mark a destination register busy.
REQ-014 SHALL have port Reserve_Addr  input  REGFILE_ADDR_WIDTH  register to reserve.
REQ-015 SHALL have port Reserve_grant  output  1  combinational acceptance of the reservation.
REQ-016 SHALL have port Busy_count  output  REGFILE_ADDR_WIDTH+1  registered count of busy registers.

Function
REQ-017 SHALL update registers at the rising edge of Clock: if Write_enable_X=1, regfile[Write_Addr_X] <= Data_In_X.
REQ-018 SHALL apply only port A when both ports write the same address in the same cycle (A wins).
REQ-019 SHALL ignore writes to address 0, and read address 0 as all zeros, when ZERO_REG=1.
REQ-020 SHALL drive reads combinationally: Data_Out_n = regfile[Read_Addr_n], with zero read latency.
REQ-021 SHALL, when BYPASS=1 and an enabled write targets Read_Addr_n in the same cycle, drive Data_Out_n with that write data, A having priority over B; when BYPASS=0, new data SHALL appear the cycle after the edge.
REQ-022 SHALL hold one busy bit per register; Ready_n = !busy[Read_Addr_n].
REQ-023 SHALL, when BYPASS=1, also assert Ready_n when an enabled write to Read_Addr_n occurs in the same cycle.
REQ-024 SHALL force Ready_n=1 for address 0 when ZERO_REG=1.
REQ-025 SHALL compute Reserve_grant = Reserve_enable & !busy[Reserve_Addr]; a reservation of an already-busy register (WAW) SHALL be refused, even if a write clears that register in the same cycle.
REQ-026 SHALL grant a reservation of address 0 when ZERO_REG=1 but leave no busy bit set.
REQ-027 SHALL clear busy[addr] at the edge on any applied write to addr; an applied write to a non-busy register SHALL leave its busy bit unchanged.
REQ-028 SHALL set busy[Reserve_Addr] at the edge on a granted reservation; when a write to the same non-busy address occurs in the same cycle, the reservation SHALL win and the bit ends set.
REQ-029 SHALL update Busy_count at each edge by (+1 per busy bit newly set) - (1 per busy bit cleared), with up to two clears (A and B at distinct busy addresses); Busy_count SHALL always equal the popcount of the busy bits and never wrap.
REQ-030 SHALL clear the busy bit only once, decrementing by 1, when A and B write the same busy address.

Reset
REQ-031 SHALL, at a rising edge with Reset_n=0, clear all registers to 0, clear all busy bits, and set Busy_count to 0.
REQ-032 SHALL give reset priority over writes and reservations in the same cycle; a reset mid-operation SHALL discard all pending reservations.
REQ-033 SHALL drive, after reset, Data_Out_n=0, Ready_n=1, and Reserve_grant=Reserve_enable.

Verification
REQ-034 SHALL verify: reset, then write A r5=0xDEADBEEF -> next cycle Read_Addr_1=5 gives 0xDEADBEEF, Ready_1=1.
REQ-035 SHALL verify: same cycle A r7=0x1, B r7=0x2 -> r7 reads 0x1; with BYPASS=1, a read of r7 in that cycle gives 0x1 combinationally.
REQ-036 SHALL verify: reserve r3 -> grant=1, Busy_count=1, Ready=0 on r3; reserve r3 again -> grant=0; write r3=0x55 -> busy cleared, Busy_count=0.
REQ-037 SHALL verify: ZERO_REG=1, write r0=0xFFFF -> r0 reads 0, Ready=1; reserve r0 -> grant=1, Busy_count stays 0.
REQ-038 SHALL verify: reserve r1, r2 on successive cycles, then A writes r1 and B writes r2 in one cycle -> Busy_count goes 2 -> 0.
REQ-039 SHALL verify: with Busy_count=3, Reset_n=0 asserted together with a write and a reservation -> all registers 0, Busy_count=0, all Ready=1.
